fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side companion of simple_fifo_sync (FWFT, sync). Drains the FIFO in bursts of BURST_LEN
//  words onto a valid/ready stream, marking the final word of each burst with m_last. Sub-burst
//  residue is flushed after TIMEOUT idle cycles or on a flush pulse. Sits directly downstream of
//  the FIFO and feeds packet/DMA logic that wants fixed-size transfers.
// PARAMETERS
//  DATA_WIDTH  16   word width; equals FIFO DATA_WIDTH
//  ADDR_WIDTH  8    FIFO ADDR_WIDTH; fifo_dat_cnt and m_len are ADDR_WIDTH+1 bits
//  BURST_LEN   16   full burst size, 1..2**ADDR_WIDTH
//  TIMEOUT     256  idle cycles before a partial burst is flushed; 0 = no timeout flush
// PORTS
//  clk            in   1               clock; all logic on rising edge
//  rst_n          in   1               asynchronous reset, active low
//  fifo_rd_ena    out  1               FIFO pop strobe (combinational, see BEHAVIOUR)
//  fifo_rd_dat    in   DATA_WIDTH      FIFO head word (FWFT)
//  fifo_rd_empty  in   1               FIFO empty
//  fifo_dat_cnt   in   ADDR_WIDTH+1    FIFO occupancy
//  flush          in   1               1-cycle request: send residue now if FIFO non-empty
//  m_valid        out  1               output word valid (registered)
//  m_ready        in   1               downstream accepts when m_valid & m_ready
//  m_data         out  DATA_WIDTH      output word (registered)
//  m_last         out  1               last word of current burst (registered)
//  m_len          out  ADDR_WIDTH+1    length of current burst, held for the whole burst
//  busy           out  1               1 while in BURST or output register occupied
// BEHAVIOUR
//  Reset (rst_n=0, any time, async): state=IDLE; rem, timer, m_len=0; m_valid, m_last, m_data,
//   fifo_rd_ena, busy=0. Burst in flight is abandoned; FIFO words already popped are lost.
//  FSM IDLE:
//   - fifo_dat_cnt >= BURST_LEN           -> BURST, len=BURST_LEN
//   - else !fifo_rd_empty & (flush | (TIMEOUT!=0 & timer==TIMEOUT-1)) -> BURST, len=fifo_dat_cnt
//   - full-burst condition wins over flush/timeout in the same cycle
//   - on entry: rem<=len, m_len<=len, timer<=0
//   - timer: +1 per IDLE cycle with FIFO non-empty and cnt<BURST_LEN; cleared when FIFO empty
//     or on BURST entry; saturates at TIMEOUT-1. flush while FIFO empty is ignored.
//  FSM BURST:
//   - pop = (rem!=0) & !fifo_rd_empty & (!m_valid | m_ready); fifo_rd_ena = pop (same cycle)
//   - on pop: m_data<=fifo_rd_dat, m_valid<=1, m_last<=(rem==1), rem<=rem-1
//   - pop with rem==1 -> IDLE next cycle; next burst may start from that IDLE cycle
//   - m_valid & m_ready & !pop -> m_valid<=0, m_last<=0
//   - fifo_rd_ena is never asserted in IDLE
//  Handshake: m_data/m_last/m_len stable while m_valid & !m_ready; m_valid never drops without
//   acceptance. Back-to-back acceptance gives 1 word/cycle (pop and accept in same cycle).
//  Latency: cnt reaches BURST_LEN at cycle N (IDLE) -> fifo_rd_ena at N+1 -> m_valid at N+2.
//  Width: rem, m_len are ADDR_WIDTH+1 bits so len=2**ADDR_WIDTH is representable; timer is
//   $clog2(TIMEOUT+1) bits (min 1).
//  Empty during BURST cannot occur (sole reader; count only grows); pop gated by !empty anyway.
//  busy = (state==BURST) | m_valid. m_len changes only on BURST entry.
// TESTING
//  1 BURST_LEN=4: write 4 words A0..A3, m_ready=1 -> m_valid 2 cycles after cnt=4; A0..A3
//    on 4 consecutive cycles, m_last only on A3, m_len=4 throughout.
//  2 Write 10 words, BURST_LEN=4, TIMEOUT=0 -> two bursts of 4 (m_last on words 4, 8);
//    2 words remain; no output until flush pulse -> burst len 2, m_last on word 10.
//  3 TIMEOUT=8, write 3 words, no more writes -> after 8 non-empty idle cycles a len-3 burst;
//    timer clears if FIFO empties via reset path; flush with empty FIFO -> no output.
//  4 Backpressure: m_ready toggled random 50% -> no word lost/duplicated, m_data/m_last
//    stable while stalled, fifo_rd_ena never high when m_valid & !m_ready.
//  5 cnt hits BURST_LEN in same cycle as flush with 2 extra words -> full burst (len=BURST_LEN)
//    chosen, not len=cnt.
//  6 rst_n pulled low mid-burst (after 2 of 4 words) -> all outputs 0 immediately (async);
//    after release FSM in IDLE, restarts cleanly on next threshold.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// Output stream of fifo_burst_reader: valid/ready words with burst framing.
// master drives valid/data/last/len and samples ready; slave is the mirror.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic [ADDR_WIDTH:0]   len;

  modport master (
    output valid,
    output data,
    output last,
    output len,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    input  len,
    output ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a FWFT FIFO in fixed bursts onto a valid/ready stream (m).
// Ports: clk, rst_n, fifo_rd_* / fifo_dat_cnt, flush, m (master), busy.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_ena,
  input  logic [DATA_WIDTH-1:0] fifo_rd_dat,
  input  logic                  fifo_rd_empty,
  input  logic [ADDR_WIDTH:0]   fifo_dat_cnt,
  input  logic                  flush,
  fifo_burst_reader_if.master   m,
  output logic                  busy
);

  localparam int TW = (TIMEOUT == 0) ? 1
                    : $clog2(TIMEOUT + 1);
  localparam int TMAX_I = (TIMEOUT == 0) ? 0
                        : TIMEOUT - 1;
  localparam logic [TW-1:0] T_MAX =
    TW'(TMAX_I);
  localparam logic [ADDR_WIDTH:0] BL =
    (ADDR_WIDTH+1)'(BURST_LEN);
  localparam bit TMO_EN = (TIMEOUT != 0);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_WIDTH:0] rem;
  logic [ADDR_WIDTH:0] len_nxt;
  logic [TW-1:0]       timer;
  logic                full_go;
  logic                tmo;
  logic                part_go;
  logic                start;
  logic                pop;
  logic                slot_free;

  assign full_go   = (fifo_dat_cnt >= BL);
  assign tmo       = TMO_EN && (timer == T_MAX);
  assign part_go   = !fifo_rd_empty
                   && (flush || tmo);
  // Output register can take a word if
  // empty or being drained this cycle.
  assign slot_free = !m.valid || m.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pop       = 1'b0;
    len_nxt   = '0;
    unique case (state)
      IDLE: begin
        // Full burst wins over flush/timeout.
        if (full_go) begin
          start     = 1'b1;
          len_nxt   = BL;
          state_nxt = BURST;
        end else if (part_go) begin
          start     = 1'b1;
          len_nxt   = fifo_dat_cnt;
          state_nxt = BURST;
        end
      end
      BURST: begin
        pop = (rem != '0)
            && !fifo_rd_empty
            && slot_free;
        if (pop && rem == 1) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign fifo_rd_ena = pop;
  assign busy        = (state == BURST)
                     || m.valid;

  // Burst bookkeeping: remaining words and
  // the length reported for the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      m.len <= '0;
    end else if (start) begin
      rem   <= len_nxt;
      m.len <= len_nxt;
    end else if (pop) begin
      rem   <= rem - 1'b1;
    end
  end

  // Idle timer: counts cycles with residue
  // waiting, saturating at the trigger value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (start) begin
      timer <= '0;
    end else if (state == IDLE) begin
      if (fifo_rd_empty) begin
        timer <= '0;
      end else if (!full_go
                   && timer != T_MAX) begin
        timer <= timer + TW'(1);
      end
    end
  end

  // Output register with valid/ready hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.valid <= 1'b0;
      m.last  <= 1'b0;
      m.data  <= '0;
    end else if (pop) begin
      m.valid <= 1'b1;
      m.last  <= (rem == 1);
      m.data  <= fifo_rd_dat;
    end else if (m.valid && m.ready) begin
      m.valid <= 1'b0;
      m.last  <= 1'b0;
    end
  end

  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    m.valid && !m.ready |=>
      m.valid
      && $stable(m.data)
      && $stable(m.last)
  );

  a_pop: assert property (
    @(posedge clk) disable iff (!rst_n)
    fifo_rd_ena |->
      (state == BURST) && slot_free
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Random + directed bench for fifo_burst_reader.
// Queue FIFO model and transaction-level reference.
module tb_fifo_burst_reader;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int BL  = 4;
  localparam int TO  = 8;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_ena;
  logic [DW-1:0] fifo_rd_dat;
  logic          fifo_rd_empty;
  logic [AW:0]   fifo_dat_cnt;
  logic          flush;
  logic          busy;

  fifo_burst_reader_if #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) m_if ();

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_ena  (fifo_rd_ena),
    .fifo_rd_dat  (fifo_rd_dat),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_dat_cnt (fifo_dat_cnt),
    .flush        (flush),
    .m            (m_if),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_q[$];
  int            len_q[$];
  int            mdl_left;
  int            mdl_idle;
  int            mdl_mlen;
  int            out_idx;
  bit            pend_pop;
  int            pend_nw;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            n_cmp;
  int            n_bad;
  int            cyc;
  int            n_acc;
  int            n_last;
  bit            lat_arm;
  int            t_c;
  int            t_e;
  int            t_v;
  int            t_l;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive();
    fifo_rd_empty = (q.size() == 0);
    fifo_rd_dat   = (q.size() != 0) ? q[0] : '0;
    fifo_dat_cnt  = (AW+1)'(q.size());
  endtask

  task automatic model();
    int  sz;
    int  len;
    bit  go;
    bit  exp_pop;
    bit  exp_last;
    logic [DW-1:0] d;
    chk("m_len", 32'(m_if.len), 32'(mdl_mlen));
    chk("busy", 32'(busy),
        32'((mdl_left != 0) || m_if.valid));
    if (prev_stall) begin
      chk("hold_valid", 32'(m_if.valid), 1);
      chk("hold_data", 32'(m_if.data),
          32'(prev_data));
      chk("hold_last", 32'(m_if.last),
          32'(prev_last));
    end
    if (m_if.valid && m_if.ready) begin
      n_acc++;
      if (m_if.last) n_last++;
      if (lat_arm && m_if.last && t_l < 0)
        t_l = cyc;
      if (exp_q.size() == 0) begin
        chk("extra_word", 1, 0);
      end else begin
        d = exp_q.pop_front();
        chk("data", 32'(m_if.data), 32'(d));
        out_idx++;
        exp_last = (len_q.size() != 0)
                && (out_idx == len_q[0]);
        chk("last", 32'(m_if.last),
            32'(exp_last));
        if (exp_last) begin
          void'(len_q.pop_front());
          out_idx = 0;
        end
      end
    end
    prev_stall = m_if.valid && !m_if.ready;
    prev_data  = m_if.data;
    prev_last  = m_if.last;
    sz = q.size();
    if (mdl_left == 0) begin
      chk("rd_ena_idle", 32'(fifo_rd_ena), 0);
      go  = 1'b0;
      len = 0;
      if (sz >= BL) begin
        go  = 1'b1;
        len = BL;
      end else if (sz > 0 &&
                   (flush || mdl_idle == TO-1)) begin
        go  = 1'b1;
        len = sz;
      end
      if (go) begin
        mdl_left = len;
        mdl_mlen = len;
        len_q.push_back(len);
        mdl_idle = 0;
      end else if (sz == 0) begin
        mdl_idle = 0;
      end else if (mdl_idle < TO-1) begin
        mdl_idle++;
      end
    end else begin
      exp_pop = (sz > 0)
             && (!m_if.valid || m_if.ready);
      chk("rd_ena", 32'(fifo_rd_ena),
          32'(exp_pop));
      if (exp_pop) mdl_left--;
    end
  endtask

  task automatic step(
    input int nw,
    input bit rdy,
    input bit fl
  );
    logic [DW-1:0] d;
    @(negedge clk);
    rst_n = 1'b1;
    if (pend_pop && q.size() != 0)
      void'(q.pop_front());
    for (int i = 0; i < pend_nw; i++) begin
      d = DW'($urandom);
      q.push_back(d);
      exp_q.push_back(d);
    end
    pend_nw = (q.size() + nw <= CAP) ? nw : 0;
    m_if.ready = rdy;
    flush      = fl;
    drive();
    #1;
    cyc++;
    if (lat_arm) begin
      if (t_c < 0 && q.size() >= BL) t_c = cyc;
      if (t_e < 0 && fifo_rd_ena) t_e = cyc;
      if (t_v < 0 && m_if.valid) t_v = cyc;
    end
    model();
    pend_pop = fifo_rd_ena;
  endtask

  task automatic resync();
    pend_pop   = 1'b0;
    mdl_left   = 0;
    mdl_idle   = 0;
    mdl_mlen   = 0;
    out_idx    = 0;
    prev_stall = 1'b0;
    len_q.delete();
    exp_q = q;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(m_if.valid), 0);
    chk({tag, "_last"}, 32'(m_if.last), 0);
    chk({tag, "_data"}, 32'(m_if.data), 0);
    chk({tag, "_len"}, 32'(m_if.len), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ena"}, 32'(fifo_rd_ena), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc0;
    bit hit;
    n_cmp = 0; n_bad = 0; cyc = 0;
    n_acc = 0; n_last = 0;
    pend_nw = 0;
    lat_arm = 1'b0;
    t_c = -1; t_e = -1; t_v = -1; t_l = -1;
    m_if.ready = 1'b0;
    flush = 1'b0;
    drive();
    resync();
    #1;
    chk_zero("reset");

    repeat (3) step(0, 1, 0);

    // Full burst latency and back-to-back words
    lat_arm = 1'b1;
    base = n_acc;
    repeat (4) step(1, 1, 0);
    repeat (10) step(0, 1, 0);
    lat_arm = 1'b0;
    chk("t1_lat_ena", 32'(t_e - t_c), 1);
    chk("t1_lat_valid", 32'(t_v - t_c), 2);
    chk("t1_last_at", 32'(t_l - t_v), 3);
    chk("t1_words", 32'(n_acc - base), 4);
    chk("t1_len", 32'(m_if.len), 4);

    // Residue flushed by a pulse
    base = n_last;
    repeat (6) step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    step(0, 1, 1);
    repeat (8) step(0, 1, 0);
    chk("t2_bursts", 32'(n_last - base), 2);
    chk("t2_len", 32'(m_if.len), 2);

    // Residue flushed by timeout
    base = n_last;
    repeat (3) step(1, 1, 0);
    repeat (25) step(0, 1, 0);
    chk("t3_bursts", 32'(n_last - base), 1);
    chk("t3_len", 32'(m_if.len), 3);
    acc0 = n_acc;
    repeat (4) step(0, 1, 1);
    chk("t3_empty_flush",
        32'(n_acc - acc0), 0);
    chk("t3_idle_busy", 32'(busy), 0);

    // Full burst beats flush with 6 words
    step(2, 1, 0);
    step(4, 1, 0);
    step(0, 1, 1);
    repeat (2) step(0, 1, 0);
    chk("t5_len", 32'(m_if.len), 4);
    repeat (20) step(0, 1, 0);

    // Async reset mid-burst
    base = n_acc;
    repeat (4) step(1, 1, 0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(0, 1, 0);
      hit = (n_acc - base >= 2);
    end
    chk("t6_reach", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    resync();
    @(posedge clk);
    #1;
    chk("t6_rst_hold", 32'(m_if.valid), 0);
    repeat (4) step(1, 1, 0);
    repeat (5) step(0, 1, 0);
    chk("t6_len", 32'(m_if.len), 4);
    repeat (20) step(0, 1, 0);

    // Random traffic with backpressure
    for (int i = 0; i < 1500; i++) begin
      int r;
      int nw;
      r  = int'($urandom_range(0, 9));
      nw = (r < 4) ? 1 : (r == 9) ? 2 : 0;
      step(nw, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0));
    end

    // Drain everything out
    for (int i = 0; i < 300; i++)
      step(0, 1, (i % 16) == 0);
    chk("drain_fifo", 32'(q.size()), 0);
    chk("drain_words", 32'(exp_q.size()), 0);
    chk("drain_bursts", 32'(len_q.size()), 0);
    chk("drain_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
